// File: rtl/dma_pcis_rd_responder_if.sv
// AXI4 read channels plus the 512-bit result stream seen by the DMA PCIS read responder.
interface dma_pcis_rd_responder_if #(
    parameter int unsigned ID_W   = 6,
    parameter int unsigned DATA_W = 512
);
    logic [ID_W-1:0]   s_arid;
    logic [63:0]       s_araddr;
    logic [7:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic              s_arvalid;
    logic              s_arready;
    logic [ID_W-1:0]   s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic              s_rready;
    logic [DATA_W-1:0] str_tdata;
    logic              str_tvalid;
    logic              str_tready;

    // Requester / stream-source side
    modport master (
        output s_arid, s_araddr, s_arlen, s_arsize, s_arvalid, s_rready,
        output str_tdata, str_tvalid,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid, str_tready
    );

    // Responder side
    modport slave (
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arvalid, s_rready,
        input  str_tdata, str_tvalid,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid, str_tready
    );
endinterface

// File: rtl/dma_pcis_rd_responder.sv
// Burst-accurate AXI4 read responder: frames the width-converter stream into R bursts per queued AR.
// Optional stall timeout (SLVERR beats) enabled by defining DMA_PCIS_RD_TIMEOUT_EN.
module dma_pcis_rd_responder #(
    parameter int unsigned ID_W           = 6,
    parameter int unsigned DATA_W         = 512,
    parameter int unsigned AR_DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    dma_pcis_rd_responder_if.slave    bus,
    output logic [$clog2(AR_DEPTH):0] outstanding,
    output logic [15:0]               err_beats
);
    localparam int unsigned PTR_W = $clog2(AR_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_W-1:0]   id_mem  [AR_DEPTH];
    logic [7:0]        len_mem [AR_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              arready_q, arready_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic              rvalid_q, rvalid_d;

    logic push_c, pop_c, head_valid_c, can_load_c, load_c, head_last_c, tmo_beat_c;
    logic unused_ar_c;

    assign unused_ar_c = ^{bus.s_araddr, bus.s_arsize};

    assign push_c       = bus.s_arvalid && arready_q;
    assign head_valid_c = (cnt_q != '0);
    assign can_load_c   = head_valid_c && (!rvalid_q || bus.s_rready);
    assign load_c       = can_load_c && (bus.str_tvalid || tmo_beat_c);
    assign head_last_c  = (beat_cnt_q == len_mem[rd_ptr_q]);
    assign pop_c        = load_c && head_last_c;

    assign bus.str_tready = can_load_c;
    assign bus.s_arready  = arready_q;
    assign bus.s_rid      = rid_q;
    assign bus.s_rdata    = rdata_q;
    assign bus.s_rresp    = rresp_q;
    assign bus.s_rlast    = rlast_q;
    assign bus.s_rvalid   = rvalid_q;
    assign outstanding    = cnt_q;

`ifdef DMA_PCIS_RD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [15:0]      err_q, err_d;

    // A stream beat always wins; the error beat only replaces a missing one.
    assign tmo_beat_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) && !bus.str_tvalid;
    assign err_beats  = err_q;

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (load_c) begin
            tmo_d = '0;
        end else if (can_load_c && !bus.str_tvalid) begin
            tmo_d = tmo_q + 1'b1;
        end
        if (load_c && tmo_beat_c && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    localparam int unsigned UNUSED_TMO = TIMEOUT_CYCLES;

    assign tmo_beat_c = 1'b0;
    assign err_beats  = '0;
`endif

    // Queue pointers, occupancy, head beat counter and output stage next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_cnt_d = beat_cnt_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        rvalid_d   = rvalid_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d     = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        arready_d = (cnt_d != CNT_W'(AR_DEPTH));

        if (load_c) begin
            beat_cnt_d = head_last_c ? 8'd0 : beat_cnt_q + 8'd1;
            rid_d      = id_mem[rd_ptr_q];
            rdata_d    = bus.str_tvalid ? bus.str_tdata : '0;
            rresp_d    = bus.str_tvalid ? 2'b00 : 2'b10;
            rlast_d    = head_last_c;
            rvalid_d   = 1'b1;
        end else if (bus.s_rready) begin
            rvalid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            arready_q  <= 1'b0;
            beat_cnt_q <= '0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            arready_q  <= arready_d;
            beat_cnt_q <= beat_cnt_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Queue storage needs no reset: entries are only read while occupancy says valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            id_mem[wr_ptr_q]  <= bus.s_arid;
            len_mem[wr_ptr_q] <= bus.s_arlen;
        end
    end
endmodule

// File: tb/tb_dma_pcis_rd_responder.sv
// Randomized self-checking bench for dma_pcis_rd_responder with a transaction-level scoreboard.
module tb_dma_pcis_rd_responder;
    localparam int unsigned ID_W   = 6;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TMO    = 16;

    typedef struct { int id; int len; } ar_t;
    typedef struct { int id; bit last; int unsigned didx; } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [$clog2(DEPTH):0] outstanding;
    logic [15:0] err_beats;

    dma_pcis_rd_responder_if #(.ID_W(ID_W), .DATA_W(DATA_W)) bus ();

    dma_pcis_rd_responder #(
        .ID_W(ID_W), .DATA_W(DATA_W), .AR_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .outstanding(outstanding), .err_beats(err_beats)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ar_cyc = 0;
    int unsigned rready_pct = 0;
    int unsigned tvalid_pct = 0;
    int unsigned str_cnt = 0;
    bit mon_en = 0;
    bit up = 0;

    ar_t   ldq[$];
    beat_t rexp[$];
    int    mcnt = 0;
    int    ld_beat = 0;
    beat_t mb;

    int log_id[$];
    int log_last[$];
    int log_cyc[$];
    int log_resp[$];
    int log_zero[$];

    bit stall_prev = 0;
    logic [ID_W-1:0]   prev_rid;
    logic [DATA_W-1:0] prev_rdata;
    logic [1:0]        prev_rresp;
    logic              prev_rlast;

    function automatic logic [DATA_W-1:0] data_of(input int unsigned k);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = k * 32'h9E3779B1 + 32'(i);
        return d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst) up <= rst ? 1'b0 : 1'b1;

    initial forever begin
        @(posedge clk); #1;
        bus.s_rready = ($urandom_range(99) < rready_pct);
    end

    initial forever begin
        @(posedge clk); #1;
        bus.str_tvalid = ($urandom_range(99) < tvalid_pct);
        bus.str_tdata  = data_of(str_cnt);
    end

    // Monitor: compare against the queue model, then advance it with the handshakes of the coming edge
    always @(negedge clk) begin
        if (rst) begin
            ldq.delete(); rexp.delete();
            mcnt = 0; ld_beat = 0; stall_prev = 0;
        end else begin
            if (mon_en) begin
                chk("arready", 64'(bus.s_arready), 64'(up && (mcnt != int'(DEPTH))));
                chk("outstanding", 64'(outstanding), 64'(mcnt));
                chk("str_tready", 64'(bus.str_tready), 64'((mcnt != 0) && (!bus.s_rvalid || bus.s_rready)));
                chk("rvalid", 64'(bus.s_rvalid), 64'(rexp.size() != 0));
                chk("err_beats", 64'(err_beats), 64'd0);
                if (stall_prev) begin
                    chk("stable_rid", 64'(bus.s_rid), 64'(prev_rid));
                    chk("stable_rlast", 64'(bus.s_rlast), 64'(prev_rlast));
                    chk("stable_rresp", 64'(bus.s_rresp), 64'(prev_rresp));
                    chkw("stable_rdata", bus.s_rdata, prev_rdata);
                end
                if (bus.s_rvalid && bus.s_rready && rexp.size() != 0) begin
                    mb = rexp[0];
                    chk("rid", 64'(bus.s_rid), 64'(mb.id));
                    chk("rlast", 64'(bus.s_rlast), 64'(mb.last));
                    chk("rresp", 64'(bus.s_rresp), 64'd0);
                    chkw("rdata", bus.s_rdata, data_of(mb.didx));
                end
            end
            if (bus.s_rvalid && bus.s_rready) begin
                log_id.push_back(int'(bus.s_rid));
                log_last.push_back(int'(bus.s_rlast));
                log_cyc.push_back(cyc);
                log_resp.push_back(int'(bus.s_rresp));
                log_zero.push_back(int'(bus.s_rdata == '0));
                if (rexp.size() != 0) void'(rexp.pop_front());
            end
            if (bus.str_tvalid && bus.str_tready) begin
                if (ldq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL stream_consumed_without_ar: got tready 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mb.id = ldq[0].id;
                    mb.last = (ld_beat == ldq[0].len);
                    mb.didx = str_cnt;
                    rexp.push_back(mb);
                    if (mb.last) begin
                        void'(ldq.pop_front()); ld_beat = 0; mcnt--;
                    end else begin
                        ld_beat++;
                    end
                end
                str_cnt++;
            end
            if (bus.s_arvalid && bus.s_arready) begin
                ldq.push_back('{int'(bus.s_arid), int'(bus.s_arlen)});
                mcnt++;
                ar_cyc = cyc;
            end
            stall_prev = bus.s_rvalid && !bus.s_rready;
            prev_rid   = bus.s_rid;
            prev_rdata = bus.s_rdata;
            prev_rresp = bus.s_rresp;
            prev_rlast = bus.s_rlast;
        end
    end

    task automatic clear_log();
        log_id.delete(); log_last.delete(); log_cyc.delete(); log_resp.delete(); log_zero.delete();
    endtask

    // Called and returns at posedge+1 so back-to-back calls hold arvalid continuously
    task automatic send_ar(input int id, input int len);
        int n;
        n = 0;
        bus.s_arid    = ID_W'(id);
        bus.s_arlen   = 8'(len);
        bus.s_araddr  = {$urandom, $urandom};
        bus.s_arsize  = 3'd6;
        bus.s_arvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_arready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!bus.s_arready) begin
            fails++;
            $display("FAIL ar_handshake: got no arready in %0d cycles expected accept", n);
        end
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((ldq.size() != 0 || rexp.size() != 0) && n < limit);
        tests++;
        if (ldq.size() != 0 || rexp.size() != 0) begin
            fails++;
            $display("FAIL idle_wait: got %0d ARs %0d beats pending expected 0", ldq.size(), rexp.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arready"}, 64'(bus.s_arready), 64'd0);
        chk({tag, "_rvalid"}, 64'(bus.s_rvalid), 64'd0);
        chk({tag, "_rlast"}, 64'(bus.s_rlast), 64'd0);
        chk({tag, "_rid"}, 64'(bus.s_rid), 64'd0);
        chkw({tag, "_rdata"}, bus.s_rdata, '0);
        chk({tag, "_rresp"}, 64'(bus.s_rresp), 64'd0);
        chk({tag, "_str_tready"}, 64'(bus.str_tready), 64'd0);
        chk({tag, "_outstanding"}, 64'(outstanding), 64'd0);
        chk({tag, "_err_beats"}, 64'(err_beats), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_beats;
        int nlast;
        bus.s_arvalid = 1'b0; bus.s_arid = '0; bus.s_arlen = '0; bus.s_araddr = '0; bus.s_arsize = '0;
        bus.s_rready = 1'b0; bus.str_tvalid = 1'b0; bus.str_tdata = '0;

        // Reset values and arready rising on the first edge after release
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arready_before_first_edge", 64'(bus.s_arready), 64'd0);
        @(negedge clk);
        chk("arready_after_first_edge", 64'(bus.s_arready), 64'd1);
        mon_en = 1;
        @(posedge clk); #1;

        // Single burst: id 5, four beats starting two cycles after the handshake
        tvalid_pct = 100; rready_pct = 100;
        @(posedge clk); #1;
        clear_log();
        send_ar(5, 3);
        wait_idle(100);
        chk("single_beats", 64'(log_id.size()), 64'd4);
        if (log_id.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("single_cycle", 64'(log_cyc[i] - ar_cyc), 64'(2 + i));
                chk("single_rid", 64'(log_id[i]), 64'd5);
                chk("single_rlast", 64'(log_last[i]), 64'(i == 3));
            end
        end
        chk("single_outstanding", 64'(outstanding), 64'd0);

        // Queue full: five back-to-back ARs with R stalled
        rready_pct = 0;
        @(posedge clk); #1;
        clear_log();
        fork
            begin
                for (int i = 0; i < 5; i++) send_ar(10 + i, 3);
            end
            begin
                repeat (8) @(negedge clk);
                chk("full_arready", 64'(bus.s_arready), 64'd0);
                chk("full_outstanding", 64'(outstanding), 64'd4);
                rready_pct = 100;
            end
        join
        wait_idle(200);
        chk("full_beats", 64'(log_id.size()), 64'd20);
        if (log_id.size() == 20) begin
            for (int i = 0; i < 20; i++) chk("full_order", 64'(log_id[i]), 64'(10 + i / 4));
        end

        // Backpressure on a 256-beat burst
        rready_pct = 60; tvalid_pct = 60;
        clear_log();
        send_ar(22, 255);
        wait_idle(5000);
        nlast = 0;
        foreach (log_last[i]) nlast += log_last[i];
        chk("long_beats", 64'(log_id.size()), 64'd256);
        chk("long_rlast_count", 64'(nlast), 64'd1);
        if (log_last.size() == 256) chk("long_rlast_pos", 64'(log_last[255]), 64'd1);

        // Random mix of short bursts under random flow control
        clear_log();
        exp_beats = 0;
        for (int k = 0; k < 24; k++) begin
            int id, len;
            id = int'($urandom_range(63));
            len = int'($urandom_range(15));
            exp_beats += len + 1;
            rready_pct = $urandom_range(100, 30);
            tvalid_pct = $urandom_range(100, 60);
            send_ar(id, len);
        end
        wait_idle(5000);
        chk("mix_beats", 64'(log_id.size()), 64'(exp_beats));

        // Reset in the middle of an 8-beat burst
        rready_pct = 100; tvalid_pct = 100;
        @(posedge clk); #1;
        clear_log();
        send_ar(3, 7);
        begin
            int n;
            n = 0;
            while (log_id.size() < 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("midrst_reached_beat2", 64'(log_id.size() >= 3), 64'd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        send_ar(1, 0);
        wait_idle(100);
        chk("post_rst_beats", 64'(log_id.size()), 64'd1);
        if (log_id.size() == 1) begin
            chk("post_rst_rid", 64'(log_id[0]), 64'd1);
            chk("post_rst_rlast", 64'(log_last[0]), 64'd1);
        end

        // Stream starved: timeout beats when enabled, otherwise an indefinite wait
        mon_en = 0;
        tvalid_pct = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear_log();
        send_ar(9, 1);
`ifdef DMA_PCIS_RD_TIMEOUT_EN
        repeat (60) @(negedge clk);
        chk("tmo_beats", 64'(log_id.size()), 64'd2);
        if (log_id.size() == 2) begin
            chk("tmo_first_cycle", 64'(log_cyc[0] - ar_cyc), 64'(TMO + 1));
            chk("tmo_gap", 64'(log_cyc[1] - log_cyc[0]), 64'(TMO));
            chk("tmo_resp0", 64'(log_resp[0]), 64'd2);
            chk("tmo_resp1", 64'(log_resp[1]), 64'd2);
            chk("tmo_zero0", 64'(log_zero[0]), 64'd1);
            chk("tmo_zero1", 64'(log_zero[1]), 64'd1);
            chk("tmo_last0", 64'(log_last[0]), 64'd0);
            chk("tmo_last1", 64'(log_last[1]), 64'd1);
            chk("tmo_rid", 64'(log_id[1]), 64'd9);
        end
        chk("tmo_err_beats", 64'(err_beats), 64'd2);
        chk("tmo_outstanding", 64'(outstanding), 64'd0);
`else
        repeat (10000) @(negedge clk);
        chk("starve_beats", 64'(log_id.size()), 64'd0);
        chk("starve_rvalid", 64'(bus.s_rvalid), 64'd0);
        chk("starve_err_beats", 64'(err_beats), 64'd0);
        chk("starve_outstanding", 64'(outstanding), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dma_pcis_rd_responder.md
# dma_pcis_rd_responder

Read-side AXI4 responder for the DMA PCIS slave port. Sits directly downstream of the 64-to-512 width converter, consuming its 512-bit result stream. Returns that stream on the R channel with correct `rid`, per-burst `rlast` and `rresp`, driven by queued AR requests. Replaces free-running image counting with burst-accurate framing.

## Interface
Parameters:
- `ID_W`, 6, AXI ID width
- `DATA_W`, 512, R data / stream width
- `AR_DEPTH`, 4, AR request queue entries (power of 2, ≥2)
- `TIMEOUT_CYCLES`, 4096, stall cycles before error beat (only with timeout feature)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `s_arid`  in  ID_W  read ID
- `s_araddr`  in  64  address (ignored; data is streamed)
- `s_arlen`  in  8  beats minus one
- `s_arsize`  in  3  ignored (full-width beats)
- `s_arvalid`  in  1  AR valid
- `s_arready`  out  1  AR ready
- `s_rid`  out  ID_W  ID of the burst in service
- `s_rdata`  out  DATA_W  beat data
- `s_rresp`  out  2  `2'b00` OKAY, `2'b10` SLVERR
- `s_rlast`  out  1  last beat of burst
- `s_rvalid`  out  1  R valid
- `s_rready`  in  1  R ready
- `str_tdata`  in  DATA_W  result stream data
- `str_tvalid`  in  1  stream valid
- `str_tready`  out  1  stream ready
- `outstanding`  out  $clog2(AR_DEPTH)+1  AR entries queued, including the head
- `err_beats`  out  16  saturating count of SLVERR beats issued

## Operation
- AR queue: FIFO of {arid, arlen}, AR_DEPTH deep. Push on `s_arvalid & s_arready`. `s_arready` is registered and equals not-full as of the previous edge. No push/pop pass-through, so a full queue stalls AR for at least one cycle after a pop.
- Head entry: `beat_cnt` (8 bit) counts beats loaded for the head burst.
- Output register: one stage holds {rid, rdata, rresp, rlast, rvalid}. It loads when the head is valid and (`!s_rvalid | s_rready`). The load source is:
  - stream beat: `str_tvalid`, rresp OKAY; or
  - timeout beat: rdata zero, rresp SLVERR.
- `str_tready` = head valid & (`!s_rvalid | s_rready`). The stream is never consumed without a queued request.
- `s_rlast` is loaded as (`beat_cnt == arlen`). On that load, pop the head and clear `beat_cnt`. Otherwise increment `beat_cnt`.
- `arlen` = 0 gives a single beat with `rlast` = 1. `arlen` = 255 gives 256 beats, and `beat_cnt` must not wrap early.
- Bursts are returned strictly in AR order. No interleaving.
- Push and pop in the same cycle: `outstanding` is unchanged.

## Timing
- Reset values: `s_arready` 0, `s_rvalid` 0, `s_rlast` 0, `s_rid` 0, `s_rdata` 0, `s_rresp` 0, `str_tready` 0, `outstanding` 0, `err_beats` 0. Queue is empty, `beat_cnt` is 0, timeout counter is 0.
- `s_arready` rises on the first edge after `rst` deasserts.
- Latency: AR handshake in cycle 0 with `str_tvalid` held high gives `s_rvalid` in cycle 2.
- Throughput: one beat per cycle sustained while `s_rready`, `str_tvalid` and the queue stay valid.
- Output is AXI-stable: while `s_rvalid & !s_rready`, all R outputs hold and `str_tready` = 0.
- Reset mid-burst: everything returns to reset values immediately. The partial burst and queued requests are dropped, and no further stream data is consumed.

## Configuration
- `DMA_PCIS_RD_TIMEOUT_EN` defined:
  - A counter increments each cycle the head is valid, the output register can load, and `str_tvalid` = 0. It clears on any load.
  - On reaching TIMEOUT_CYCLES−1, the next load is a timeout beat. The beat counts toward the burst, so `rlast` and pop apply normally.
  - `err_beats` increments per SLVERR beat and saturates at 0xFFFF.
- Not defined: no counter. R waits on the stream indefinitely, `s_rresp` is always 0, and `err_beats` is tied to 0.

## Test plan
- Single burst: AR id=5, arlen=3, stream always valid, `s_rready`=1 → 4 beats in cycles 2–5, rid=5, `rlast` only on beat 3, rdata matches stream order, `outstanding` back to 0.
- Queue full: 5 ARs back-to-back with `s_rready`=0 and AR_DEPTH=4 → 4 accepted, `s_arready`=0, `outstanding`=4. Raise `s_rready` → 5th AR accepted ≥1 cycle after first pop, and ids return in order.
- Backpressure: random `s_rready` and `str_tvalid` over arlen=255 → exactly 256 beats, no drop or duplicate, outputs stable while stalled, single `rlast`.
- Reset mid-burst: assert `rst` after beat 2 of arlen=7 → outputs 0 the same cycle; after release, a new AR id=1 arlen=0 → one beat, rid=1, `rlast`=1.
- With `DMA_PCIS_RD_TIMEOUT_EN`, TIMEOUT_CYCLES=16: AR arlen=1, `str_tvalid`=0 → two SLVERR zero beats ~16 cycles apart, second with `rlast`, `err_beats`=2.
- Without the macro, same stimulus: no R beats after 10000 cycles, `err_beats`=0.
